// File: rtl/div_sequencer.sv
// Multi-cycle radix-2 restoring divide controller for DIV/DIVU.
// Holds the pipeline with stall, then pulses ready with {remainder, quotient}.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sign,
  input  logic               annul,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BYZERO, ON, END} stateType;

  stateType       state, nextState;
  logic [CW-1:0]  counter;
  logic [2*WIDTH:0] work;
  logic [WIDTH-1:0] divisor;
  logic           negQ, negR;

  logic           accept, loadOn, loadZero;
  logic           divByZero;
  logic [WIDTH-1:0] absDividend, absDivisor;
  logic [2*WIDTH:0] shifted, stepped;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quoFix, remFix;

  assign divByZero   = (opdata2 == '0);
  assign absDividend = (sign && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign absDivisor  = (sign && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: shift, trial-subtract from the upper bits, keep or restore.
  assign shifted = work << 1;
  assign trial   = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b0, divisor};
  assign stepped = trial[WIDTH+1] ? shifted
                                  : {trial[WIDTH:0], shifted[WIDTH-1:1], 1'b1};

  assign quoFix = negQ ? -stepped[WIDTH-1:0]       : stepped[WIDTH-1:0];
  assign remFix = negR ? -stepped[2*WIDTH-1:WIDTH] : stepped[2*WIDTH-1:WIDTH];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    nextState = state;
    stall     = 1'b0;
    accept    = 1'b0;
    loadOn    = 1'b0;
    loadZero  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !annul) begin
          accept    = 1'b1;
          stall     = 1'b1;
          nextState = divByZero ? BYZERO : ON;
        end
      end
      BYZERO: begin
        stall = 1'b1;
        if (annul) begin
          nextState = IDLE;
        end else begin
          loadZero  = 1'b1;
          nextState = END;
        end
      end
      ON: begin
        stall = 1'b1;
        if (annul) begin
          nextState = IDLE;
        end else if (counter == CW'(WIDTH-1)) begin
          loadOn    = 1'b1;
          nextState = END;
        end
      end
      END: begin
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
      work    <= '0;
      divisor <= '0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      result  <= '0;
      ready   <= 1'b0;
    end else begin
      ready <= loadOn | loadZero;
      if (accept) begin
        // A zero divisor keeps the raw dividend so it can be returned as the remainder.
        work    <= {(WIDTH+1)'(0), divByZero ? opdata1 : absDividend};
        divisor <= absDivisor;
        negQ    <= sign & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
        negR    <= sign & opdata1[WIDTH-1];
        counter <= '0;
      end
      if (state == ON) begin
        work    <= stepped;
        counter <= counter + CW'(1);
      end
      if (loadOn) begin
        result <= {remFix, quoFix};
      end
      if (loadZero) begin
        result <= {work[WIDTH-1:0], {WIDTH{1'b1}}};
      end
    end
  end

endmodule
